// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter: widths, the
// hard-wired zero register and the arbitration state encoding.
package wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        PRI_A  = 2'd0,
        PRI_B  = 2'd1,
        LOCK_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux_5bit.sv
// Two-way 5-bit select used on the register destination address path.
module mux_5bit (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       ctrl,
    output logic [4:0] y
);

    assign y = ctrl ? a : b;

endmodule

// File: rtl/wb_port_arbiter.sv
// Per-cycle arbiter sharing the single register-file write port between the
// ALU pipe (A) and the mul/div unit (B), including B's 2-beat HI/LO bursts.
module wb_port_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_last,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              mux_sel,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              b_locked
);

    import wb_pkg::*;

    // Handshake: a beat transfers in the cycle its valid and ready are both
    // high; ready is only raised for the single winning source with valid set.
    arb_state_t        state;
    arb_state_t        state_next;
    logic              grant_a;
    logic              grant_b;
    logic [ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PRI_A;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        state_next = state;
        if (!rst) begin
            unique case (state)
                PRI_A: begin
                    if (a_valid) begin
                        grant_a    = 1'b1;
                        state_next = PRI_B;
                    end else if (b_valid) begin
                        grant_b    = 1'b1;
                        state_next = b_last ? PRI_A : LOCK_B;
                    end
                end
                PRI_B: begin
                    if (b_valid) begin
                        grant_b    = 1'b1;
                        state_next = b_last ? PRI_A : LOCK_B;
                    end else if (a_valid) begin
                        grant_a    = 1'b1;
                        state_next = PRI_B;
                    end
                end
                LOCK_B: begin
                    // A stays blocked until the burst's final beat is taken.
                    if (b_valid) begin
                        grant_b    = 1'b1;
                        state_next = b_last ? PRI_A : LOCK_B;
                    end
                end
                default: state_next = PRI_A;
            endcase
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    mux_5bit u_addr_mux (
        .a    (a_waddr),
        .b    (b_waddr),
        .ctrl (grant_a),
        .y    (sel_waddr)
    );

    assign sel_wdata = grant_a ? a_wdata : b_wdata;

    // Writes to the zero register are consumed but never reach the file.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            mux_sel  <= 1'b1;
        end else begin
            rf_we <= (grant_a | grant_b) && (sel_waddr != ADDR_W'(REG_ZERO));
            if (grant_a | grant_b) begin
                rf_waddr <= sel_waddr;
                rf_wdata <= sel_wdata;
                mux_sel  <= grant_a;
            end
        end
    end

    assign b_locked = (state == LOCK_B);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: contention, bursts, $0, same-address
// ordering, idle hold and asynchronous reset in the middle of a burst.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic        a_ready;
    logic [4:0]  a_waddr;
    logic [63:0] a_wdata;
    logic        b_valid;
    logic        b_ready;
    logic        b_last;
    logic [4:0]  b_waddr;
    logic [63:0] b_wdata;
    logic        mux_sel;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        b_locked;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] DA = 64'h1111;
    localparam logic [63:0] DB = 64'h2222;
    localparam logic [63:0] HI = 64'hAAAA_0000;
    localparam logic [63:0] LO = 64'h0000_BBBB;

    wb_port_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_waddr  (a_waddr),
        .a_wdata  (a_wdata),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_last   (b_last),
        .b_waddr  (b_waddr),
        .b_wdata  (b_wdata),
        .mux_sel  (mux_sel),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .b_locked (b_locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                         input logic bv, input logic bl, input logic [4:0] ba,
                         input logic [63:0] bd);
        @(negedge clk);
        a_valid = av;
        a_waddr = aa;
        a_wdata = ad;
        b_valid = bv;
        b_last  = bl;
        b_waddr = ba;
        b_wdata = bd;
    endtask

    task automatic check_ready(input string tag, input logic ea, input logic eb);
        #1;
        chk({tag, ".a_ready"}, 64'(a_ready), 64'(ea));
        chk({tag, ".b_ready"}, 64'(b_ready), 64'(eb));
    endtask

    task automatic check_out(input string tag, input logic we, input logic chk_ad,
                             input logic [4:0] addr, input logic [63:0] data,
                             input logic sel, input logic lock);
        @(posedge clk);
        #1;
        chk({tag, ".rf_we"}, 64'(rf_we), 64'(we));
        if (chk_ad) begin
            chk({tag, ".rf_waddr"}, 64'(rf_waddr), 64'(addr));
            chk({tag, ".rf_wdata"}, rf_wdata, data);
        end
        chk({tag, ".mux_sel"}, 64'(mux_sel), 64'(sel));
        chk({tag, ".b_locked"}, 64'(b_locked), 64'(lock));
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_last = 1'b0; b_waddr = '0; b_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rf_we", 64'(rf_we), 64'd0);
        chk("reset.rf_waddr", 64'(rf_waddr), 64'd0);
        chk("reset.rf_wdata", rf_wdata, 64'd0);
        chk("reset.mux_sel", 64'(mux_sel), 64'd1);
        chk("reset.b_locked", 64'(b_locked), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Both sources valid every cycle: grants alternate starting with A.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, DA, 1'b1, 1'b1, 5'd7, DB);
            if (i % 2 == 0) begin
                check_ready("contend_a", 1'b1, 1'b0);
                check_out("contend_a", 1'b1, 1'b1, 5'd3, DA, 1'b1, 1'b0);
            end else begin
                check_ready("contend_b", 1'b0, 1'b1);
                check_out("contend_b", 1'b1, 1'b1, 5'd7, DB, 1'b0, 1'b0);
            end
        end

        // A alone moves priority to B, then a B burst locks A out.
        drive(1'b1, 5'd4, 64'h4444, 1'b0, 1'b0, 5'd0, 64'd0);
        check_ready("pre_burst", 1'b1, 1'b0);
        check_out("pre_burst", 1'b1, 1'b1, 5'd4, 64'h4444, 1'b1, 1'b0);
        drive(1'b1, 5'd4, 64'h4444, 1'b1, 1'b0, 5'd5, HI);
        check_ready("burst_hi", 1'b0, 1'b1);
        check_out("burst_hi", 1'b1, 1'b1, 5'd5, HI, 1'b0, 1'b1);
        drive(1'b1, 5'd4, 64'h4444, 1'b0, 1'b0, 5'd0, 64'd0);
        check_ready("burst_gap", 1'b0, 1'b0);
        check_out("burst_gap", 1'b0, 1'b1, 5'd5, HI, 1'b0, 1'b1);
        drive(1'b1, 5'd4, 64'h4444, 1'b1, 1'b1, 5'd6, LO);
        check_ready("burst_lo", 1'b0, 1'b1);
        check_out("burst_lo", 1'b1, 1'b1, 5'd6, LO, 1'b0, 1'b0);
        drive(1'b1, 5'd4, 64'h4444, 1'b0, 1'b0, 5'd0, 64'd0);
        check_ready("post_burst", 1'b1, 1'b0);
        check_out("post_burst", 1'b1, 1'b1, 5'd4, 64'h4444, 1'b1, 1'b0);

        // Write to $0 is accepted but suppressed.
        drive(1'b1, 5'd0, 64'hDEAD, 1'b0, 1'b0, 5'd0, 64'd0);
        check_ready("zero_reg", 1'b1, 1'b0);
        check_out("zero_reg", 1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 1'b0);

        // Single B write returns priority to A.
        drive(1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 5'd1, 64'h55);
        check_ready("b_single", 1'b0, 1'b1);
        check_out("b_single", 1'b1, 1'b1, 5'd1, 64'h55, 1'b0, 1'b0);

        // Same destination r9: A's value lands first, B's value last.
        drive(1'b1, 5'd9, 64'd1, 1'b1, 1'b1, 5'd9, 64'd2);
        check_ready("same_addr_1", 1'b1, 1'b0);
        check_out("same_addr_1", 1'b1, 1'b1, 5'd9, 64'd1, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 64'd0, 1'b1, 1'b1, 5'd9, 64'd2);
        check_ready("same_addr_2", 1'b0, 1'b1);
        check_out("same_addr_2", 1'b1, 1'b1, 5'd9, 64'd2, 1'b0, 1'b0);

        // Idle: nothing written, write-port address/data/select hold.
        drive(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        for (int i = 0; i < 10; i++) begin
            check_ready("idle", 1'b0, 1'b0);
            check_out("idle", 1'b0, 1'b1, 5'd9, 64'd2, 1'b0, 1'b0);
            @(negedge clk);
        end

        // Open a burst, then reset in the middle of the next cycle.
        b_valid = 1'b1; b_last = 1'b0; b_waddr = 5'd12; b_wdata = 64'h77;
        check_ready("lock_pre_rst", 1'b0, 1'b1);
        check_out("lock_pre_rst", 1'b1, 1'b1, 5'd12, 64'h77, 1'b0, 1'b1);
        drive(1'b1, 5'd3, DA, 1'b1, 1'b1, 5'd13, 64'h88);
        #2;
        rst = 1'b1;
        check_ready("mid_rst", 1'b0, 1'b0);
        chk("mid_rst.rf_we", 64'(rf_we), 64'd0);
        chk("mid_rst.rf_waddr", 64'(rf_waddr), 64'd0);
        chk("mid_rst.mux_sel", 64'(mux_sel), 64'd1);
        chk("mid_rst.b_locked", 64'(b_locked), 64'd0);
        check_out("in_rst", 1'b0, 1'b1, 5'd0, 64'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_ready("after_rst", 1'b1, 1'b0);
        check_out("after_rst", 1'b1, 1'b1, 5'd3, DA, 1'b1, 1'b0);

        drive(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0, 64'd0);
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
